// File: rtl/pico_mem_responder_if.sv
// ----------------------------------------------------------------------------
// pico_mem_responder_if
//
// Purpose:
//   Bundles the pico_L1 native memory link between the initiator (CPU-side
//   cache) and the memory responder into one interface.
//
// Signals:
//   mem_valid  initiator -> memory  request valid, held until mem_ready
//   mem_instr  initiator -> memory  instruction-fetch qualifier
//   mem_addr   initiator -> memory  byte address (ADDR_WIDTH bits)
//   mem_wdata  initiator -> memory  write data
//   mem_wstrb  initiator -> memory  byte write enables, 0 means read
//   mem_ready  memory -> initiator  one-cycle response strobe
//   mem_rdata  memory -> initiator  read data, valid while mem_ready is high
//
// Modports:
//   master  the initiator side
//   slave   the memory responder side
// ----------------------------------------------------------------------------
interface pico_mem_responder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  mem_valid;
    logic                  mem_instr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/pico_mem_responder.sv
// ----------------------------------------------------------------------------
// pico_mem_responder
//
// Purpose:
//   Synthesizable memory end of the pico_L1 native memory link. Holds a
//   word-addressed RAM, applies byte-strobe writes, returns the pre-write word
//   as read data and paces every response with a programmable number of wait
//   states. Consecutive responses are always separated by at least one idle
//   cycle.
//
// Parameters:
//   ADDR_WIDTH   byte address width of mem_addr
//   DEPTH_WORDS  number of 32-bit RAM words
//   WAIT_CYCLES  extra cycles between request accept and mem_ready (0..15)
//
// Ports:
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   bus           pico_mem_responder_if.slave (valid/instr/addr/wdata/wstrb
//                 in, ready/rdata out)
//   busy          high from accept up to and including the mem_ready cycle
//   access_count  completed transactions, wraps at 16 bits
//   err           out-of-range strobe during the response cycle
//
// Build option:
//   MEM_RANGE_ERR_EN  when defined, out-of-range requests are accepted and
//                     answered with rdata=0 and err=1 (no RAM write). When
//                     undefined, err is tied low and such requests stall.
// ----------------------------------------------------------------------------
module pico_mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    pico_mem_responder_if.slave        bus,
    output logic                       busy,
    output logic [15:0]                access_count,
    output logic                       err
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state_q,    state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [RAM_AW-1:0] word_q,     word_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [3:0]        wstrb_q,    wstrb_d;
    logic              instr_q,    instr_d;
    logic              oor_q,      oor_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [15:0]       count_q,    count_d;

    logic [31:0] ram [DEPTH_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic              req_in_range;
    logic              accept;

    // RAM access controls for the edge that enters RESP
    logic              commit;
    logic [RAM_AW-1:0] acc_word;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_wstrb;
    logic              acc_oor;

    assign req_idx      = bus.mem_addr[ADDR_WIDTH-1:2];
    assign req_in_range = 32'(req_idx) < 32'(DEPTH_WORDS);

`ifdef MEM_RANGE_ERR_EN
    // Out-of-range requests are taken and answered with an error strobe
    assign accept = bus.mem_valid;
`else
    // Out-of-range requests are never taken, so the initiator stalls
    assign accept = bus.mem_valid && req_in_range;
`endif

    // Next-state logic. With zero wait states the RAM is accessed on the same
    // edge that accepts the request, so the live bus fields are used instead
    // of the not-yet-latched copies.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        instr_d    = instr_q;
        oor_d      = oor_q;
        rdata_d    = rdata_q;
        count_d    = count_q;
        commit     = 1'b0;
        acc_word   = word_q;
        acc_wdata  = wdata_q;
        acc_wstrb  = wstrb_q;
        acc_oor    = oor_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = req_idx[RAM_AW-1:0];
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
                    instr_d = bus.mem_instr;
                    oor_d   = !req_in_range;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d   = ST_RESP;
                        commit    = 1'b1;
                        acc_word  = req_idx[RAM_AW-1:0];
                        acc_wdata = bus.mem_wdata;
                        acc_wstrb = bus.mem_wstrb;
                        acc_oor   = !req_in_range;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // The leaving edge never accepts, guaranteeing an idle gap
                state_d = ST_IDLE;
                count_d = count_q + 16'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (commit) begin
            rdata_d = acc_oor ? 32'h0 : ram[acc_word];
        end
    end

    // Control and response registers; RAM contents are deliberately excluded
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            word_q     <= '0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            instr_q    <= 1'b0;
            oor_q      <= 1'b0;
            rdata_q    <= 32'h0;
            count_q    <= 16'h0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            instr_q    <= instr_d;
            oor_q      <= oor_d;
            rdata_q    <= rdata_d;
            count_q    <= count_d;
        end
    end

    // Byte-strobed RAM write. Gated by resetn so a request presented while
    // reset is held can never land in the array.
    always_ff @(posedge clk) begin
        if (commit && resetn && !acc_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    ram[acc_word][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = (state_q == ST_RESP);
    assign bus.mem_rdata = rdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign access_count  = count_q;

`ifdef MEM_RANGE_ERR_EN
    assign err = (state_q == ST_RESP) && oor_q;
`else
    assign err = 1'b0;
`endif

    // The fetch qualifier and the byte offset carry no function here
    logic unused_sink;
    assign unused_sink = ^{instr_q, bus.mem_addr[1:0]};

endmodule

// File: tb/tb_pico_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_pico_mem_responder
//
// Purpose:
//   Self-checking bench for pico_mem_responder. Two instances are driven, one
//   with no wait states and one with three, both with a 64-word RAM. A
//   reference model holds the expected memory image, the expected response
//   latency (wait states + 1 cycles after the accept edge) and the expected
//   transaction count.
//
// Ports:
//   none (top-level bench)
// ----------------------------------------------------------------------------
module tb_pico_mem_responder;

    localparam int DEPTH = 64;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    pico_mem_responder_if #(.ADDR_WIDTH(9)) bus0 ();
    pico_mem_responder_if #(.ADDR_WIDTH(9)) bus1 ();

    logic        busy0, busy1;
    logic [15:0] cnt0,  cnt1;
    logic        err0,  err1;

    pico_mem_responder #(.ADDR_WIDTH(9), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus0),
        .busy         (busy0),
        .access_count (cnt0),
        .err          (err0)
    );

    pico_mem_responder #(.ADDR_WIDTH(9), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut1 (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus1),
        .busy         (busy1),
        .access_count (cnt1),
        .err          (err1)
    );

    int          total = 0;
    int          bad   = 0;
    int          waitc [2];
    logic [31:0] model_mem [2][DEPTH];
    bit          known [2][DEPTH];
    int          model_cnt [2];
    bit          turn_pending [2];
    logic [31:0] last_rd;

    // Single point of comparison: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdyOf(input int d);
        return (d == 0) ? bus0.mem_ready : bus1.mem_ready;
    endfunction

    function automatic logic [31:0] rdataOf(input int d);
        return (d == 0) ? bus0.mem_rdata : bus1.mem_rdata;
    endfunction

    function automatic logic busyOf(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    function automatic logic errOf(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic logic [15:0] cntOf(input int d);
        return (d == 0) ? cnt0 : cnt1;
    endfunction

    // Drives all request fields of one bus
    task automatic drive(input int d, input logic v, input logic [8:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, input logic ins);
        if (d == 0) begin
            bus0.mem_valid = v; bus0.mem_addr = a; bus0.mem_wdata = wd;
            bus0.mem_wstrb = ws; bus0.mem_instr = ins;
        end else begin
            bus1.mem_valid = v; bus1.mem_addr = a; bus1.mem_wdata = wd;
            bus1.mem_wstrb = ws; bus1.mem_instr = ins;
        end
    endtask

    task automatic setValid(input int d, input logic v);
        if (d == 0) bus0.mem_valid = v;
        else        bus1.mem_valid = v;
    endtask

    // One complete transaction against the model. With keep set, mem_valid
    // stays high into the next call, which then expects a turnaround edge.
    task automatic applyStimulus(input int d, input logic [8:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input bit keep);
        int          idx;
        bit          oor;
        int          cycles;
        bit          seen;
        bit          busy_ok;
        logic [31:0] merged;
        idx = int'(addr[8:2]);
        oor = (idx >= DEPTH);
        drive(d, 1'b1, addr, wdata, wstrb, 1'($urandom_range(0, 1)));
        if (turn_pending[d]) begin
            @(posedge clk); #1;
            checkOutput("gap_ready", 32'(rdyOf(d)), 32'h0);
            checkOutput("gap_count", 32'(cntOf(d)), 32'(model_cnt[d] % 65536));
            turn_pending[d] = 1'b0;
        end
        seen    = 1'b0;
        busy_ok = 1'b1;
        cycles  = 0;
        while (!seen && cycles < waitc[d] + 8) begin
            @(posedge clk); #1;
            cycles++;
            if (rdyOf(d)) seen = 1'b1;
            else if (!busyOf(d)) busy_ok = 1'b0;
        end
        checkOutput("latency", seen ? 32'(cycles) : 32'h0, 32'(waitc[d] + 1));
        if (!seen) begin
            setValid(d, 1'b0);
            @(posedge clk); #1;
            return;
        end
        checkOutput("busy_wait", 32'(busy_ok), 32'h1);
        checkOutput("busy_resp", 32'(busyOf(d)), 32'h1);
        last_rd = rdataOf(d);
        if (oor) begin
            checkOutput("oor_rdata", last_rd, 32'h0);
            checkOutput("oor_err", 32'(errOf(d)), 32'h1);
        end else begin
            if (known[d][idx]) checkOutput("rdata", last_rd, model_mem[d][idx]);
            checkOutput("err", 32'(errOf(d)), 32'h0);
            merged = model_mem[d][idx];
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
            end
            model_mem[d][idx] = merged;
            if (wstrb == 4'hF) known[d][idx] = 1'b1;
        end
        model_cnt[d]++;
        if (keep) begin
            turn_pending[d] = 1'b1;
        end else begin
            setValid(d, 1'b0);
            @(posedge clk); #1;
            checkOutput("ready_pulse", 32'(rdyOf(d)), 32'h0);
            checkOutput("busy_after", 32'(busyOf(d)), 32'h0);
            checkOutput("count", 32'(cntOf(d)), 32'(model_cnt[d] % 65536));
        end
    endtask

    // Bounded run time regardless of DUT behaviour
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          seen;
        bit          bseen;
        int          idx;
        logic [3:0]  ws;
        bit          keep;
        waitc[0] = 0;
        waitc[1] = 3;
        for (int d = 0; d < 2; d++) begin
            model_cnt[d]    = 0;
            turn_pending[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                known[d][i]     = 1'b0;
                model_mem[d][i] = 32'h0;
            end
            drive(d, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0);
        end

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_ready", 32'(rdyOf(d)), 32'h0);
            checkOutput("rst_busy", 32'(busyOf(d)), 32'h0);
            checkOutput("rst_err", 32'(errOf(d)), 32'h0);
            checkOutput("rst_count", 32'(cntOf(d)), 32'h0);
            checkOutput("rst_rdata", rdataOf(d), 32'h0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // Fill both memories so every word has a known value
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(d, 9'(i * 4), $urandom, 4'hF, 1'b0);
            end
        end

        // Plain read of a preloaded word
        applyStimulus(0, 9'h000, 32'h3fc00093, 4'hF, 1'b0);
        applyStimulus(0, 9'h000, 32'h0, 4'h0, 1'b0);
        checkOutput("tp_read", last_rd, 32'h3fc00093);

        // Byte-strobe write returns the old word, then the merged word reads back
        applyStimulus(0, 9'h014, 32'h11223344, 4'hF, 1'b0);
        applyStimulus(0, 9'h014, 32'hAABBCCDD, 4'b0101, 1'b0);
        checkOutput("tp_wr_old", last_rd, 32'h11223344);
        applyStimulus(0, 9'h014, 32'h0, 4'h0, 1'b0);
        checkOutput("tp_merge", last_rd, 32'h11BB33DD);

        // Wait-state instance: latency 4 and busy across all four cycles
        applyStimulus(1, 9'h000, 32'h0, 4'h0, 1'b0);

        // Out-of-range word index 127 on a 64-word RAM
`ifdef MEM_RANGE_ERR_EN
        applyStimulus(0, 9'h1FC, 32'hCAFEF00D, 4'hF, 1'b0);
`else
        drive(0, 1'b1, 9'h1FC, 32'hCAFEF00D, 4'hF, 1'b0);
        seen  = 1'b0;
        bseen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rdyOf(0)) seen = 1'b1;
            if (busyOf(0)) bseen = 1'b1;
        end
        setValid(0, 1'b0);
        checkOutput("oor_stall_ready", 32'(seen), 32'h0);
        checkOutput("oor_stall_busy", 32'(bseen), 32'h0);
        checkOutput("oor_stall_err", 32'(errOf(0)), 32'h0);
        @(posedge clk); #1;
`endif
        // Aliased word 63 must be untouched
        applyStimulus(0, 9'h0FC, 32'h0, 4'h0, 1'b0);

        // Randomized bursts, sometimes holding mem_valid across transactions
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 25; n++) begin
                idx  = $urandom_range(0, DEPTH - 1);
                ws   = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                keep = (n != 24) && ($urandom_range(0, 1) == 1);
                applyStimulus(d, {idx[6:0], 2'($urandom_range(0, 3))}, $urandom, ws, keep);
            end
        end

        // Reset during the wait phase of a write to word 2
        drive(1, 1'b1, 9'h008, 32'hDEADBEEF, 4'hF, 1'b0);
        @(posedge clk); #1;
        checkOutput("midrst_busy", 32'(busyOf(1)), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midrst_pre_ready", 32'(rdyOf(1)), 32'h0);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_busy_clr", 32'(busyOf(1)), 32'h0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rdyOf(1)) seen = 1'b1;
        end
        setValid(1, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("midrst_no_ready", 32'(seen), 32'h0);
        for (int d = 0; d < 2; d++) begin
            model_cnt[d]    = 0;
            turn_pending[d] = 1'b0;
            checkOutput("midrst_count", 32'(cntOf(d)), 32'h0);
            checkOutput("midrst_rdata", rdataOf(d), 32'h0);
        end
        applyStimulus(1, 9'h008, 32'h0, 4'h0, 1'b0);

        // Back-to-back reads with mem_valid held high
        applyStimulus(0, 9'h000, 32'h0, 4'h0, 1'b1);
        applyStimulus(0, 9'h004, 32'h0, 4'h0, 1'b1);
        applyStimulus(0, 9'h008, 32'h0, 4'h0, 1'b0);
        checkOutput("b2b_count", 32'(cntOf(0)), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
